// File: rtl/bsg_xnor_transition_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bsg_xnor_transition_decoder
// Description : Decodes an XNOR-transition-encoded word stream. Each encoded
//               beat is XNORed with a reference register (the previously
//               decoded word) to recover the data. A sync beat carries a raw
//               word that resynchronises the reference. The output is a single
//               valid/yumi register, so the block runs at full throughput.
//
// Parameters  : width_p  - data word width. Must be overridden and be >= 1.
//                          The default 0 marks an invalid, unconfigured
//                          instance.
//               seed_p   - reference word loaded at reset.
//
// Ports       : clk_i      in   clock, all state changes on its rising edge
//               reset_n_i  in   asynchronous active-low reset
//               v_i        in   input beat valid
//               data_i     in   encoded word (raw word when sync_i=1)
//               sync_i     in   beat is a raw resynchronisation word
//               parity_i   in   even parity of the decoded word
//               ready_o    out  a beat can be accepted this cycle
//               v_o        out  decoded word valid
//               data_o     out  decoded word
//               yumi_i     in   consumer takes data_o this cycle
//               err_o      out  sticky parity-error flag
//
// Build macro : BSG_XNOR_TRANSITION_DECODER_PARITY_EN
//               Defined   -> parity_i is checked against the XOR reduction of
//                            each accepted decoded word; err_o is sticky.
//               Undefined -> parity_i is ignored and err_o is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_xnor_transition_decoder #(
    parameter int                 width_p = 0,
    parameter logic [width_p-1:0] seed_p  = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               sync_i,
    input  logic               parity_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               err_o
);

    logic               r_v;
    logic [width_p-1:0] r_data;
    logic [width_p-1:0] r_ref;

    logic               w_accept;
    logic [width_p-1:0] w_decoded;

    // The output register frees up either when empty or when it is being
    // consumed this cycle, which allows back-to-back beats without bubbles.
    assign ready_o  = ~r_v | yumi_i;
    assign w_accept = v_i & ready_o;

    // Purely bitwise: each output bit depends only on the same bit position.
    assign w_decoded = sync_i ? data_i : ~(data_i ^ r_ref);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_ref  <= seed_p;
        end else begin
            if (w_accept) begin
                r_v    <= 1'b1;
                r_data <= w_decoded;
                r_ref  <= w_decoded;
            end else if (yumi_i) begin
                r_v    <= 1'b0;
            end
        end
    end

    assign v_o    = r_v;
    assign data_o = r_data;

`ifdef BSG_XNOR_TRANSITION_DECODER_PARITY_EN
    logic r_err;

    // Even parity: the supplied bit must equal the XOR of the decoded word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if (w_accept && (parity_i != (^w_decoded))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    // Parity input is intentionally left unconnected in this build.
    logic w_unused_parity;
    assign w_unused_parity = parity_i;
    assign err_o           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_xnor_transition_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_xnor_transition_decoder
// Description : Self-checking bench for bsg_xnor_transition_decoder
//               (width_p=8, seed_p=8'h00). Directed scenarios followed by
//               random traffic, all compared against a transaction-level
//               model of the decoder kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_xnor_transition_decoder;

    localparam int c_width = 8;

    logic               clk;
    logic               reset_n;
    logic               v_i;
    logic [c_width-1:0] data_i;
    logic               sync_i;
    logic               parity_i;
    logic               ready_o;
    logic               v_o;
    logic [c_width-1:0] data_o;
    logic               yumi_i;
    logic               err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: last decoded word, held output, sticky error.
    logic [c_width-1:0] m_ref;
    logic [c_width-1:0] m_data;
    logic               m_v;
    logic               m_err;

    bsg_xnor_transition_decoder #(
        .width_p (c_width),
        .seed_p  (8'h00)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .sync_i    (sync_i),
        .parity_i  (parity_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_width-1:0] decode(input logic [c_width-1:0] d, input logic s);
        return s ? d : ~(d ^ m_ref);
    endfunction

    function automatic logic even_par(input logic [c_width-1:0] w);
        logic p = 1'b0;
        for (int i = 0; i < c_width; i++) p = p ^ w[i];
        return p;
    endfunction

    task automatic model_reset();
        m_ref  = 8'h00;
        m_data = 8'h00;
        m_v    = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check ready, clock, check outputs.
    task automatic step(input string tag, input logic v, input logic [c_width-1:0] d,
                        input logic s, input logic p, input logic y);
        logic               acc;
        logic [c_width-1:0] dec;
        @(negedge clk);
        v_i = v; data_i = d; sync_i = s; parity_i = p; yumi_i = y;
        #1;
        chk({tag, ".ready"}, {31'd0, ready_o}, {31'd0, (!m_v) || y});
        acc = v && ((!m_v) || y);
        dec = decode(d, s);
        @(posedge clk);
        #1;
        if (acc) begin
            m_ref  = dec;
            m_data = dec;
            m_v    = 1'b1;
`ifdef BSG_XNOR_TRANSITION_DECODER_PARITY_EN
            if (p != even_par(dec)) m_err = 1'b1;
`endif
        end else if (y) begin
            m_v = 1'b0;
        end
        chk({tag, ".v_o"},    {31'd0, v_o},   {31'd0, m_v});
        if (m_v) chk({tag, ".data_o"}, {24'd0, data_o}, {24'd0, m_data});
        chk({tag, ".err_o"},  {31'd0, err_o}, {31'd0, m_err});
    endtask

    task automatic beat(input string tag, input logic [c_width-1:0] d, input logic s, input logic y);
        step(tag, 1'b1, d, s, even_par(decode(d, s)), y);
    endtask

    initial begin
        logic [c_width-1:0] d;
        logic               s, v, y, p;

        v_i = 0; data_i = 0; sync_i = 0; parity_i = 0; yumi_i = 0;
        reset_n = 1'b0;
        model_reset();
        #12;
        chk("reset.v_o",    {31'd0, v_o},     32'd0);
        chk("reset.ready",  {31'd0, ready_o}, 32'd1);
        chk("reset.data_o", {24'd0, data_o},  32'd0);
        chk("reset.err_o",  {31'd0, err_o},   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two plain beats against the seed, then a sync and a dependent beat.
        beat("b5a", 8'h5A, 1'b0, 1'b0);
        chk("b5a.lit", {24'd0, data_o}, 32'hA5);
        beat("bff", 8'hFF, 1'b0, 1'b1);
        chk("bff.lit", {24'd0, data_o}, 32'hA5);
        beat("sync3c", 8'h3C, 1'b1, 1'b1);
        chk("sync3c.lit", {24'd0, data_o}, 32'h3C);
        beat("bc3", 8'hC3, 1'b0, 1'b1);
        chk("bc3.lit", {24'd0, data_o}, 32'h00);

        // Backpressure: sender holds a beat while the output is not consumed.
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        chk("hold.lit", {24'd0, data_o}, 32'h00);
        beat("release", 8'h81, 1'b0, 1'b1);
        chk("release.lit", {24'd0, data_o}, 32'h7E);

        // Streaming with continuous consumption: no bubbles.
        beat("s0", 8'h12, 1'b0, 1'b1);
        beat("s1", 8'h34, 1'b0, 1'b1);
        beat("s2", 8'hF0, 1'b1, 1'b1);
        beat("s3", 8'h0F, 1'b0, 1'b1);
        chk("s3.lit", {24'd0, data_o}, 32'h00);

        // Asynchronous reset while holding a word.
        @(negedge clk);
        v_i = 0; yumi_i = 0;
        reset_n = 1'b0;
        #1;
        chk("areset.v_o",    {31'd0, v_o},    32'd0);
        chk("areset.data_o", {24'd0, data_o}, 32'd0);
        chk("areset.ready",  {31'd0, ready_o}, 32'd1);
        model_reset();
        #2 reset_n = 1'b1;
        beat("post_rst", 8'hFF, 1'b0, 1'b0);
        chk("post_rst.lit", {24'd0, data_o}, 32'h00);

        // Parity error: decoded 8'h01 with parity 0.
        step("perr", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        beat("pgood0", 8'h55, 1'b0, 1'b1);
        beat("pgood1", 8'hAA, 1'b1, 1'b1);
`ifdef BSG_XNOR_TRANSITION_DECODER_PARITY_EN
        chk("perr.sticky", {31'd0, err_o}, 32'd1);
`else
        chk("perr.off", {31'd0, err_o}, 32'd0);
`endif

        // Random traffic; yumi only when output is valid.
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            s = ($urandom_range(0, 7) == 0);
            y = m_v && ($urandom_range(0, 2) != 0);
            p = even_par(decode(d, s)) ^ ($urandom_range(0, 40) == 0);
            step("rand", v, d, s, p, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
